// File: rtl/scr1_tcm_pl.sv
// Pipelined dual-port TCM: IMEM read port + DMEM read/write port, configurable read latency.
// Define SCR1_TCM_MISALIGN_CHK_EN to turn misaligned accesses into error responses.
module scr1_tcm_pl #(
  parameter int unsigned SCR1_TCM_SIZE    = 32'h00010000,
  parameter int unsigned SCR1_TCM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_req,
  input  logic [31:0] imem_addr,
  output logic        imem_req_ack,
  output logic [31:0] imem_rdata,
  output logic [1:0]  imem_resp,
  input  logic        dmem_req,
  input  logic        dmem_cmd,
  input  logic [1:0]  dmem_width,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic        dmem_req_ack,
  output logic [31:0] dmem_rdata,
  output logic [1:0]  dmem_resp
);

  localparam int unsigned AW    = $clog2(SCR1_TCM_SIZE);
  localparam int unsigned DEPTH = SCR1_TCM_SIZE / 4;
  localparam int unsigned LAT   = SCR1_TCM_LATENCY;

  logic [31:0]   mem [DEPTH];
  logic [AW-3:0] i_idx, d_idx;
  logic          i_err, d_err;
  logic          i_rd_en, d_rd_en, d_we;
  logic [3:0]    d_be;
  logic [31:0]   d_wdata;

  logic [31:0]   i_dat_q [LAT];
  logic [31:0]   d_dat_q [LAT];
  logic [LAT-1:0] i_vld_q, i_err_q, d_vld_q, d_err_q;
  logic [1:0]    d_sh_q [LAT];

  logic          unused_addr_bits;

  assign i_idx = imem_addr[AW-1:2];
  assign d_idx = dmem_addr[AW-1:2];
  assign unused_addr_bits = ^{imem_addr[31:AW], dmem_addr[31:AW], imem_addr[1:0]};

`ifdef SCR1_TCM_MISALIGN_CHK_EN
  always_comb begin
    i_err = |imem_addr[1:0];
    case (dmem_width)
      2'b00:   d_err = 1'b0;
      2'b01:   d_err = dmem_addr[0];
      default: d_err = |dmem_addr[1:0];
    endcase
  end
`else
  always_comb begin
    i_err = 1'b0;
    d_err = 1'b0;
  end
`endif

  // Errored requests never touch the array; requests during reset are ignored.
  assign i_rd_en = imem_req & ~rst & ~i_err;
  assign d_rd_en = dmem_req & ~rst & ~d_err & ~dmem_cmd;
  assign d_we    = dmem_req & ~rst & ~d_err &  dmem_cmd;

  always_comb begin
    case (dmem_width)
      2'b00: begin
        d_be    = 4'b0001 << dmem_addr[1:0];
        d_wdata = {4{dmem_wdata[7:0]}};
      end
      2'b01: begin
        d_be    = 4'b0011 << {dmem_addr[1], 1'b0};
        d_wdata = {2{dmem_wdata[15:0]}};
      end
      default: begin
        d_be    = 4'b1111;
        d_wdata = dmem_wdata;
      end
    endcase
  end

  // Read-before-write: a same-cycle IMEM read of a word being written sees the old value.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (d_we && d_be[b]) mem[d_idx][8*b +: 8] <= d_wdata[8*b +: 8];
    end
    if (i_rd_en) i_dat_q[0] <= mem[i_idx];
    if (d_rd_en) d_dat_q[0] <= mem[d_idx];
    for (int s = 1; s < int'(LAT); s++) begin
      i_dat_q[s] <= i_dat_q[s-1];
      d_dat_q[s] <= d_dat_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_vld_q <= '0;
      d_vld_q <= '0;
    end else begin
      i_vld_q[0] <= imem_req;
      i_err_q[0] <= i_err;
      d_vld_q[0] <= dmem_req;
      d_err_q[0] <= d_err;
      d_sh_q[0]  <= dmem_addr[1:0];
      for (int s = 1; s < int'(LAT); s++) begin
        i_vld_q[s] <= i_vld_q[s-1];
        i_err_q[s] <= i_err_q[s-1];
        d_vld_q[s] <= d_vld_q[s-1];
        d_err_q[s] <= d_err_q[s-1];
        d_sh_q[s]  <= d_sh_q[s-1];
      end
    end
  end

  assign imem_req_ack = 1'b1;
  assign dmem_req_ack = 1'b1;
  assign imem_rdata   = i_dat_q[LAT-1];
  assign dmem_rdata   = d_dat_q[LAT-1] >> {d_sh_q[LAT-1], 3'b000};
  assign imem_resp    = i_vld_q[LAT-1] ? (i_err_q[LAT-1] ? 2'b10 : 2'b01) : 2'b00;
  assign dmem_resp    = d_vld_q[LAT-1] ? (d_err_q[LAT-1] ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_scr1_tcm_pl.sv
// Scoreboard bench for scr1_tcm_pl: directed requests push expected responses,
// a negedge monitor pops and checks them at their due cycle.
module tb_scr1_tcm_pl;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_req_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [1:0]  imem_resp;
  logic        dmem_req, dmem_cmd, dmem_req_ack;
  logic [1:0]  dmem_width, dmem_resp;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;

  scr1_tcm_pl #(.SCR1_TCM_SIZE(32'h00010000), .SCR1_TCM_LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_req_ack(imem_req_ack),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_cmd(dmem_cmd), .dmem_width(dmem_width),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_req_ack(dmem_req_ack),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [1:0]  resp;
    logic [31:0] data;
    logic [31:0] mask;
  } exp_t;

  exp_t iq[$];
  exp_t dq[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

`ifdef SCR1_TCM_MISALIGN_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, got, exp);
    end
  endfunction

  exp_t ie, de;
  always @(negedge clk) begin
    if (iq.size() != 0 && iq[0].cyc == cyc) begin
      ie = iq.pop_front();
      check("imem_resp", {30'd0, imem_resp}, {30'd0, ie.resp});
      if (ie.mask != 0) check("imem_rdata", imem_rdata & ie.mask, ie.data);
      $display("imem txn cyc %0d resp %b rdata %h", cyc, imem_resp, imem_rdata);
    end else if (imem_resp !== 2'b00) begin
      n_checks++; n_fail++;
      $display("FAIL imem_unexpected @cyc %0d: got resp %b expected 00", cyc, imem_resp);
    end
    if (dq.size() != 0 && dq[0].cyc == cyc) begin
      de = dq.pop_front();
      check("dmem_resp", {30'd0, dmem_resp}, {30'd0, de.resp});
      if (de.mask != 0) check("dmem_rdata", dmem_rdata & de.mask, de.data);
      $display("dmem txn cyc %0d resp %b rdata %h", cyc, dmem_resp, dmem_rdata);
    end else if (dmem_resp !== 2'b00) begin
      n_checks++; n_fail++;
      $display("FAIL dmem_unexpected @cyc %0d: got resp %b expected 00", cyc, dmem_resp);
    end
  end

  task automatic cycle();
    @(negedge clk);
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_cmd = 1'b0;
  endtask

  task automatic dwr(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d,
                     input logic [1:0] r);
    exp_t e;
    dmem_req = 1'b1; dmem_cmd = 1'b1; dmem_width = w; dmem_addr = a; dmem_wdata = d;
    e.cyc = cyc + LAT; e.resp = r; e.data = '0; e.mask = '0;
    dq.push_back(e);
  endtask

  task automatic drd(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d,
                     input logic [31:0] m, input logic [1:0] r);
    exp_t e;
    dmem_req = 1'b1; dmem_cmd = 1'b0; dmem_width = w; dmem_addr = a;
    e.cyc = cyc + LAT; e.resp = r; e.data = d; e.mask = (r == 2'b01) ? m : 32'h0;
    dq.push_back(e);
  endtask

  task automatic ird(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
    exp_t e;
    imem_req = 1'b1; imem_addr = a;
    e.cyc = cyc + LAT; e.resp = r; e.data = d; e.mask = (r == 2'b01) ? 32'hFFFFFFFF : 32'h0;
    iq.push_back(e);
  endtask

  initial begin
    rst = 1'b1;
    imem_req = 0; imem_addr = 0;
    dmem_req = 0; dmem_cmd = 0; dmem_width = 0; dmem_addr = 0; dmem_wdata = 0;
    repeat (3) @(negedge clk);
    check("reset_imem_resp", {30'd0, imem_resp}, 32'd0);
    check("reset_dmem_resp", {30'd0, dmem_resp}, 32'd0);
    rst = 1'b0;

    // word write then read-after-write next cycle
    cycle(); dwr(32'h100, 2'b10, 32'hDEADBEEF, 2'b01);
    cycle(); drd(32'h100, 2'b10, 32'hDEADBEEF, 32'hFFFFFFFF, 2'b01);

    // byte writes assembled into a word, then sub-word reads with shift
    cycle(); dwr(32'h200, 2'b00, 32'h00000011, 2'b01);
    cycle(); dwr(32'h201, 2'b00, 32'h00000022, 2'b01);
    cycle(); dwr(32'h202, 2'b00, 32'h00000033, 2'b01);
    cycle(); dwr(32'h203, 2'b00, 32'h00000044, 2'b01);
    cycle(); drd(32'h200, 2'b10, 32'h44332211, 32'hFFFFFFFF, 2'b01);
    cycle(); drd(32'h202, 2'b00, 32'h00000033, 32'h000000FF, 2'b01);
    cycle(); drd(32'h202, 2'b01, 32'h00004433, 32'h0000FFFF, 2'b01);
    cycle(); dwr(32'h206, 2'b01, 32'h0000BEEF, 2'b01);
    cycle(); drd(32'h204, 2'b10, 32'hBEEF0000, 32'hFFFF0000, 2'b01);

    // back-to-back IMEM reads
    cycle(); dwr(32'h0, 2'b10, 32'h00000013, 2'b01);
    cycle(); dwr(32'h4, 2'b10, 32'h00100093, 2'b01);
    cycle(); dwr(32'h8, 2'b10, 32'h00200113, 2'b01);
    cycle(); ird(32'h0, 32'h00000013, 2'b01);
    cycle(); ird(32'h4, 32'h00100093, 2'b01);
    cycle(); ird(32'h8, 32'h00200113, 2'b01);

    // same-cycle IMEM read / DMEM write collision
    cycle(); dwr(32'h40, 2'b10, 32'h00000000, 2'b01);
    cycle();
    cycle(); ird(32'h40, 32'h00000000, 2'b01); dwr(32'h40, 2'b10, 32'hA5A5A5A5, 2'b01);
    cycle(); ird(32'h40, 32'hA5A5A5A5, 2'b01);

    // reset while two reads are in flight; a write during reset is not committed
    cycle(); dwr(32'h80, 2'b10, 32'h00000055, 2'b01);
    repeat (LAT + 1) cycle();
    cycle(); ird(32'h0, 32'h00000013, 2'b01); drd(32'h100, 2'b10, 32'hDEADBEEF, 32'hFFFFFFFF, 2'b01);
    cycle(); rst = 1'b1;
    dmem_req = 1'b1; dmem_cmd = 1'b1; dmem_width = 2'b10; dmem_addr = 32'h80; dmem_wdata = 32'h99;
    imem_req = 1'b1; imem_addr = 32'h4;
    iq.delete(); dq.delete();
    cycle(); rst = 1'b0;
    check("post_rst_imem_resp", {30'd0, imem_resp}, 32'd0);
    check("post_rst_dmem_resp", {30'd0, dmem_resp}, 32'd0);
    cycle();
    check("post_rst2_imem_resp", {30'd0, imem_resp}, 32'd0);
    check("post_rst2_dmem_resp", {30'd0, dmem_resp}, 32'd0);
    drd(32'h80, 2'b10, 32'h00000055, 32'hFFFFFFFF, 2'b01);

    // misaligned accesses
    cycle(); dwr(32'h300, 2'b10, 32'hCAFEF00D, 2'b01);
    cycle(); dwr(32'h301, 2'b10, 32'h12345678, CHK ? 2'b10 : 2'b01);
    cycle(); drd(32'h300, 2'b10, CHK ? 32'hCAFEF00D : 32'h12345678, 32'hFFFFFFFF, 2'b01);
    cycle(); ird(32'h102, 32'hDEADBEEF, CHK ? 2'b10 : 2'b01);

    // address wrap and width 11 treated as word
    cycle(); dwr(32'h00010100, 2'b10, 32'h0BADCAFE, 2'b01);
    cycle(); drd(32'h100, 2'b10, 32'h0BADCAFE, 32'hFFFFFFFF, 2'b01);
    cycle(); dwr(32'h140, 2'b11, 32'h87654321, 2'b01);
    cycle(); drd(32'h140, 2'b10, 32'h87654321, 32'hFFFFFFFF, 2'b01);

    repeat (LAT + 3) cycle();
    check("imem_queue_drained", iq.size(), 32'd0);
    check("dmem_queue_drained", dq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scr1_tcm_pl.md
# scr1_tcm_pl

Pipelined, parametrised tightly-coupled memory for the SCR1 core: one instruction read port and one data read/write port on a shared dual-port array. Read latency is configurable. Every accepted request receives exactly one single-cycle response. Optional misalignment checking returns an error response instead of touching the array. It replaces the fixed single-cycle TCM between the core's IMEM/DMEM routers and on-chip RAM.

## Interface
- SCR1_TCM_SIZE, 32'h00010000: array size in bytes; power of two, minimum 16.
- SCR1_TCM_LATENCY, 1: cycles from request acceptance to response; legal values 1..3.
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- imem_req  in  1  instruction read request.
- imem_addr  in  32  byte address; bits [1:0] ignored for the array.
- imem_req_ack  out  1  request accepted; tied 1.
- imem_rdata  out  32  read data; valid only while imem_resp==2'b01.
- imem_resp  out  2  00 idle, 01 ok, 10 error.
- dmem_req  in  1  data request.
- dmem_cmd  in  1  0 read, 1 write.
- dmem_width  in  2  00 byte, 01 halfword, 10 word.
- dmem_addr  in  32  byte address.
- dmem_wdata  in  32  write data, right-aligned.
- dmem_req_ack  out  1  tied 1.
- dmem_rdata  out  32  read data shifted right by 8*addr[1:0]; valid only while dmem_resp==2'b01.
- dmem_resp  out  2  as imem_resp.

## Operation
- Acceptance: a request is accepted in every cycle where req=1 and rst=0. There is no backpressure, so one request per port per cycle.
- Array index = addr[$clog2(SCR1_TCM_SIZE)-1:2]. Upper address bits are ignored, so addresses wrap modulo SCR1_TCM_SIZE.
- Writes:
  - Committed at the acceptance edge.
  - Byte: data replicated 4x, byte enable 4'b0001<<addr[1:0].
  - Halfword: data replicated 2x, byte enable 4'b0011<<{addr[1],0}.
  - Word: byte enable 4'b1111.
  - width 2'b11 is treated as word.
- Reads: array read registered at acceptance, then LATENCY-1 further output register stages.
- Per-port response pipeline, LATENCY deep. Each stage carries:
  - valid
  - err
  - for DMEM: addr[1:0] (shift amount)
- Response codes: at stage output, resp = 01 if valid&!err, 10 if valid&err, else 00.
- Write responses: 01 after the same LATENCY; rdata is don't-care.
- Collision, IMEM read and DMEM write to the same word in the same cycle: IMEM returns old data. A later request sees new data.
- DMEM write followed next cycle by a DMEM read of the same word: the read returns the written data.
- rdata is held when no response is presented (no zeroing required).

## Timing
- Reset: imem_resp=00, dmem_resp=00, all pipeline valid bits 0. rdata values are unspecified.
- Request accepted at edge N → resp valid during the cycle following edge N+LATENCY-1. That is, LATENCY=1 responds in the cycle right after acceptance.
- Back-to-back requests give back-to-back responses in order, with no bubbles.
- Reset mid-operation: all in-flight requests are dropped. No response is emitted for them, and resp=00 in the cycle after the reset edge. A write accepted at the edge where rst=1 is not committed.
- Asserting req during rst has no effect.

## Configuration
- SCR1_TCM_MISALIGN_CHK_EN defined:
  - DMEM halfword with addr[0]=1 is an error.
  - DMEM word with addr[1:0]!=0 is an error.
  - IMEM with addr[1:0]!=0 is an error.
  - Errored requests do not read or write the array, and respond 10 with the normal latency.
- SCR1_TCM_MISALIGN_CHK_EN undefined: no error checks, so resp is never 10.
  - Misaligned writes use the enables above (addr[0] dropped for halfword).
  - Misaligned word reads return the whole word shifted.

## Test plan
- LATENCY=1: DMEM word write 0xDEADBEEF @0x100, then read @0x100 the next cycle → dmem_resp=01 one cycle later with rdata 0xDEADBEEF.
- Byte writes 0x11,0x22,0x33,0x44 @0x200..0x203, then word read @0x200 → 0x44332211. Byte read @0x202 → rdata[7:0]=0x33.
- LATENCY=3: IMEM reads @0x0,0x4,0x8 on consecutive cycles → three consecutive 01 responses starting 3 cycles after the first acceptance, in order.
- Same-cycle IMEM read and DMEM write of 0xA5A5A5A5 @0x40 (old value 0) → imem_rdata=0. IMEM re-read → 0xA5A5A5A5.
- rst pulsed one cycle while two reads are in flight (LATENCY=2) → no responses; resp=00 from the cycle after reset.
- With SCR1_TCM_MISALIGN_CHK_EN: word write 0x12345678 @0x301 → dmem_resp=10, and a word read @0x300 returns its prior value. Address 0x10000+0x100 with SIZE 64 KiB aliases to 0x100.
